// File: rtl/idexe_skid_pipe.sv
// ID->EXE pipeline register built as a two-entry skid buffer, so in_ready
// never depends on out_ready. Also reports occupancy and a saturating stall count.
module idexe_skid_pipe #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_fire;
    logic out_fire;

    // Reset gates the handshake and status outputs combinationally, so they
    // read as idle for the whole reset cycle and not just after the edge.
    assign in_ready  = (state_q != FULL) & ~flush & ~rst;
    assign out_valid = (state_q != EMPTY) & ~rst;
    assign out_ctrl  = out_valid ? head_ctrl_q : '0;
    assign out_data  = rst ? '0 : head_data_q;
    assign occupancy = rst ? 2'd0 : state_q;
    assign stall_cnt = rst ? '0 : stall_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_d     = stall_q;

        if (out_valid && !out_ready && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end

        // Flush only empties the state; head_data is left alone so out_data does not move.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_ctrl_d = in_ctrl;
                        head_data_d = in_data;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the payload registers are reset too, because out_data
    // must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: doc/idexe_skid_pipe.md
IDEXE_SKID_PIPE -- requirements
Module: idexe_skid_pipe

Interface
Parameters:
REQ-001 SHALL provide parameter DATA_W, default 64, width of the datapath payload (operands, immediate).
REQ-002 SHALL provide parameter CTRL_W, default 16, width of the control payload (enables, ALU op, write-back destination).
REQ-003 SHALL provide parameter CNT_W, default 16, width of the stall counter.

Ports:
REQ-004 SHALL provide port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL provide port flush  input  1  discard all held and incoming entries.
REQ-007 SHALL provide port in_valid  input  1  upstream (ID) entry present.
REQ-008 SHALL provide port in_ready  output  1  stage accepts the entry this cycle.
REQ-009 SHALL provide port in_ctrl  input  CTRL_W  control payload.
REQ-010 SHALL provide port in_data  input  DATA_W  datapath payload.
REQ-011 SHALL provide port out_valid  output  1  entry presented to EXE.
REQ-012 SHALL provide port out_ready  input  1  EXE consumes the entry this cycle.
REQ-013 SHALL provide port out_ctrl  output  CTRL_W  control of the head entry.
REQ-014 SHALL provide port out_data  output  DATA_W  datapath of the head entry.
REQ-015 SHALL provide port occupancy  output  2  held entries, 0..2.
REQ-016 SHALL provide port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL implement a two-entry skid buffer with a head register (drives the outputs), a skid register, and states EMPTY, ONE and FULL.
REQ-018 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-019 SHALL drive in_ready = (state != FULL) & ~flush; in_ready SHALL NOT depend on out_ready.
REQ-020 SHALL drive out_valid = (state != EMPTY).
REQ-021 SHALL perform these transitions in EMPTY: on in_fire, load head and go to ONE; otherwise stay.
REQ-022 SHALL perform these transitions in ONE: in_fire with out_fire, load head from input and stay; in_fire only, load skid and go to FULL; out_fire only, go to EMPTY; neither, hold.
REQ-023 SHALL perform these transitions in FULL: on out_fire, copy skid to head and go to ONE; otherwise hold.
REQ-024 SHALL have a latency of 1 cycle from in_fire in EMPTY to out_valid=1, and SHALL sustain one transfer per cycle while out_ready=1.
REQ-025 SHALL preserve order, and SHALL neither drop nor duplicate entries absent flush.
REQ-026 SHALL force out_ctrl to 0 whenever out_valid=0, so that a bubble is a NOP to EXE.
REQ-027 SHALL hold out_data at its last value when out_valid=0.
REQ-028 SHALL, on flush, take priority over all transfers: the next state is EMPTY, and any head, skid or incoming entry is discarded.
REQ-029 SHALL NOT change out_data on flush.
REQ-030 SHALL drive occupancy as 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-031 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1.
REQ-032 SHALL NOT clear stall_cnt on flush.
REQ-033 SHALL hold the head and skid registers when out_valid=1 and out_ready=0, with no payload change.

Reset
REQ-034 SHALL, while rst=1, set the state to EMPTY, clear head, skid, out_data and stall_cnt to 0, and drive out_valid=0, out_ctrl=0 and occupancy=0.
REQ-035 SHALL drive in_ready=0 during any cycle with rst=1.
REQ-036 SHALL give rst priority over flush and over all transfers.
REQ-037 SHALL, on rst mid-operation, lose all held entries, with in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-038 SHALL cover streaming: out_ready=1, in_valid=1 for 4 cycles with in_data 1,2,3,4 -> out_data 1,2,3,4 on the next 4 cycles, occupancy=1 throughout, and stall_cnt=0.
REQ-039 SHALL cover skid fill: out_ready=0, offer A then B -> occupancy 1 then 2, in_ready=0 after B, out_data=A, and stall_cnt increments each cycle.
REQ-040 SHALL cover drain: from FULL(A,B) with out_ready=1 for 2 cycles -> A then B delivered, occupancy 2->1->0, and out_ctrl=0 afterwards.
REQ-041 SHALL cover flush: flush=1 in FULL with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0, incoming dropped, and stall_cnt unchanged.
REQ-042 SHALL cover stall saturation: with CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt=7.
REQ-043 SHALL cover reset mid-operation: rst=1 in FULL -> all outputs 0, then in_ready=1 the cycle after rst falls.
